vmul8_seq_ctrl: RTL and testbench

VMUL8_SEQ_CTRL -- requirements
Module: vmul8_seq_ctrl

---
 rtl/vmul_pkg.sv | 31 +++
 rtl/vmulti_4bit.sv | 39 +++
 rtl/vmul8_seq_ctrl.sv | 102 ++++++++++
 tb/tb_vmul8_seq_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/vmul_pkg.sv
// Shared definitions for the sequential 8x8 Vedic multiplier: FSM encodings,
// step schedule and partial-product alignment.
package vmul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] STEP_LL = 2'd0;
  localparam logic [1:0] STEP_HL = 2'd1;
  localparam logic [1:0] STEP_LH = 2'd2;
  localparam logic [1:0] STEP_HH = 2'd3;

  localparam int SHIFT_LL  = 0;
  localparam int SHIFT_MID = 4;
  localparam int SHIFT_HH  = 8;

  // Place an 8-bit nibble product at its weight within the 16-bit result.
  function automatic logic [15:0] align_pp(input logic [1:0] step, input logic [7:0] pp);
    logic [15:0] ext;
    ext = {8'h00, pp};
    case (step)
      STEP_LL: return ext << SHIFT_LL;
      STEP_HH: return ext << SHIFT_HH;
      default: return ext << SHIFT_MID;
    endcase
  endfunction

endpackage

// File: rtl/vmulti_4bit.sv
// 4x4 unsigned Vedic (Urdhva-Tiryagbhyam) multiplier built from four 2x2 cells.
module vmulti_4bit (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic [7:0] o_p,
  output logic       o_co
);

  function automatic logic [3:0] vedic2x2(input logic [1:0] x, input logic [1:0] y);
    logic c;
    logic [3:0] r;
    r[0] = x[0] & y[0];
    r[1] = (x[1] & y[0]) ^ (x[0] & y[1]);
    c    = (x[1] & y[0]) & (x[0] & y[1]);
    r[2] = (x[1] & y[1]) ^ c;
    r[3] = (x[1] & y[1]) & c;
    return r;
  endfunction

  logic [3:0] w_q0;
  logic [3:0] w_q1;
  logic [3:0] w_q2;
  logic [3:0] w_q3;
  logic [4:0] w_mid;
  logic [8:0] w_sum;

  assign w_q0  = vedic2x2(i_a[1:0], i_b[1:0]);
  assign w_q1  = vedic2x2(i_a[3:2], i_b[1:0]);
  assign w_q2  = vedic2x2(i_a[1:0], i_b[3:2]);
  assign w_q3  = vedic2x2(i_a[3:2], i_b[3:2]);

  // Cross terms share weight 4, so they are summed before alignment.
  assign w_mid = {1'b0, w_q1} + {1'b0, w_q2};
  assign w_sum = {5'b0, w_q0} + {2'b0, w_mid, 2'b0} + {1'b0, w_q3, 4'b0};

  assign o_p  = w_sum[7:0];
  assign o_co = w_sum[8];

endmodule

// File: rtl/vmul8_seq_ctrl.sv
// Sequential 8x8 unsigned multiplier: one 4x4 Vedic core reused over four
// MUL cycles, with valid/ready handshakes on both sides.
module vmul8_seq_ctrl
  import vmul_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] p,
  output logic        busy
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_step;
  logic [7:0]  r_a;
  logic [7:0]  r_b;
  logic [15:0] r_acc;

  logic        w_in_ready;
  logic        w_out_valid;
  logic        w_busy;
  logic        w_in_hs;
  logic        w_out_hs;
  logic [3:0]  w_nib_a;
  logic [3:0]  w_nib_b;
  logic [7:0]  w_pp;
  logic        w_unused_co;

  assign w_in_hs  = in_valid & w_in_ready;
  assign w_out_hs = w_out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_in_hs) w_state_nxt = ST_MUL;
      ST_MUL:  if (r_step == STEP_HH) w_state_nxt = ST_DONE;
      ST_DONE: begin
        if (w_in_hs)       w_state_nxt = ST_MUL;
        else if (w_out_hs) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Accepting in DONE needs out_ready so a new operand never overwrites an unread product.
  always_comb begin
    w_in_ready  = (r_state == ST_IDLE) | ((r_state == ST_DONE) & out_ready);
    w_out_valid = (r_state == ST_DONE);
    w_busy      = (r_state != ST_IDLE);
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign busy      = w_busy;

  always_ff @(posedge clk) begin
    if (rst)                   r_step <= STEP_LL;
    else if (w_in_hs)          r_step <= STEP_LL;
    else if (r_state == ST_MUL) r_step <= r_step + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a <= 8'h00;
      r_b <= 8'h00;
    end else if (w_in_hs) begin
      r_a <= a;
      r_b <= b;
    end
  end

  // step[0] picks the high nibble of a, step[1] the high nibble of b.
  assign w_nib_a = r_step[0] ? r_a[7:4] : r_a[3:0];
  assign w_nib_b = r_step[1] ? r_b[7:4] : r_b[3:0];

  vmulti_4bit u_core (
    .i_a  (w_nib_a),
    .i_b  (w_nib_b),
    .o_p  (w_pp),
    .o_co (w_unused_co)
  );

  always_ff @(posedge clk) begin
    if (rst)                    r_acc <= 16'h0000;
    else if (w_in_hs)           r_acc <= 16'h0000;
    else if (r_state == ST_MUL) r_acc <= r_acc + align_pp(r_step, w_pp);
  end

  assign p = r_acc;

endmodule

// File: tb/tb_vmul8_seq_ctrl.sv
// Directed and randomized checks of the sequential 8x8 Vedic multiplier.
module tb_vmul8_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] p;
  logic        busy;

  int n_vec;
  int n_err;

  vmul8_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = 8'h00; b = 8'h00;
    repeat (3) tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++; if (p !== 16'h0000) begin n_err++; $display("FAIL reset_p got %h want 0000", p); end
    rst = 1'b0;
    tick();
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  // One operation with out_ready=1, checking exact 4-cycle latency and return to IDLE.
  task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic [15:0] exp, input string nm);
    out_ready = 1'b1;
    a = x; b = y; in_valid = 1'b1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL %s_in_ready got %b want 1", nm, in_ready); end
    tick();
    in_valid = 1'b0; a = ~x; b = ~y;
    for (int k = 1; k <= 4; k++) begin
      if (k < 4) begin
        n_vec++; if (out_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
          n_err++; $display("FAIL %s_mul_cycle%0d got ov=%b busy=%b ir=%b want 0 1 0", nm, k, out_valid, busy, in_ready);
        end
      end
      tick();
    end
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL %s_latency got out_valid=%b want 1", nm, out_valid); end
    n_vec++; if (p !== exp) begin n_err++; $display("FAIL %s_p got %h want %h", nm, p, exp); end
    tick();
    n_vec++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL %s_idle got ov=%b busy=%b want 0 0", nm, out_valid, busy);
    end
  endtask

  task automatic test_basic();
    run_op(8'h12, 8'h34, 16'h03A8, "basic");
  endtask

  task automatic test_corners();
    run_op(8'hFF, 8'hFF, 16'hFE01, "max");
    run_op(8'h00, 8'hAB, 16'h0000, "zero");
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    a = 8'hA5; b = 8'h5A; in_valid = 1'b1;
    tick();
    a = 8'h11; b = 8'h22;
    repeat (4) tick();
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stall_done got out_valid=%b want 1", out_valid); end
    for (int i = 0; i < 6; i++) begin
      n_vec++; if (out_valid !== 1'b1 || p !== 16'h3A02 || in_ready !== 1'b0) begin
        n_err++; $display("FAIL stall_hold%0d got ov=%b p=%h ir=%b want 1 3a02 0", i, out_valid, p, in_ready);
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_vec++; if (p !== 16'h3A02) begin n_err++; $display("FAIL stall_final_p got %h want 3a02", p); end
    tick();
    n_vec++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL stall_release got ov=%b busy=%b want 0 0", out_valid, busy);
    end
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stall_single got out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    int t1;
    int t2;
    logic [15:0] p1;
    logic [15:0] p2;
    t1 = -1; t2 = -1; p1 = 16'h0; p2 = 16'h0;
    out_ready = 1'b1;
    a = 8'h0F; b = 8'h0F; in_valid = 1'b1;
    tick();
    a = 8'h10; b = 8'h10;
    for (int i = 1; i <= 30 && t2 < 0; i++) begin
      if (t1 >= 0 && i == t1 + 2) in_valid = 1'b0;
      tick();
      if (out_valid === 1'b1) begin
        if (t1 < 0) begin t1 = i; p1 = p; end
        else if (i > t1) begin t2 = i; p2 = p; end
      end
    end
    in_valid = 1'b0;
    n_vec++; if (t1 != 4) begin n_err++; $display("FAIL b2b_first_latency got %0d want 4", t1); end
    n_vec++; if (p1 !== 16'h00E1) begin n_err++; $display("FAIL b2b_p1 got %h want 00e1", p1); end
    n_vec++; if (t2 - t1 != 5 || t2 < 0) begin n_err++; $display("FAIL b2b_spacing got %0d want 5", t2 - t1); end
    n_vec++; if (p2 !== 16'h0100) begin n_err++; $display("FAIL b2b_p2 got %h want 0100", p2); end
    tick();
    n_vec++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL b2b_idle got ov=%b busy=%b want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    a = 8'h33; b = 8'h44; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++; if (p !== 16'h0000 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL rstmid_state got p=%h ov=%b busy=%b want 0000 0 0", p, out_valid, busy);
    end
    tick();
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_in_ready got %b want 1", in_ready); end
    for (int i = 0; i < 6; i++) begin
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_no_output%0d got %b want 0", i, out_valid); end
      tick();
    end
    run_op(8'h03, 8'h05, 16'h000F, "rstmid_next");
  endtask

  task automatic test_random();
    logic [15:0] q[$];
    logic [15:0] exp;
    int sent;
    int recv;
    int cyc;
    logic in_hs;
    logic out_hs;
    logic [15:0] p_s;
    sent = 0; recv = 0; cyc = 0;
    in_valid = 1'b0;
    while (recv < 1000 && cyc < 20000) begin
      if (!in_valid && sent < 1000 && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
      end
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      in_hs = in_valid & in_ready;
      out_hs = out_valid & out_ready;
      p_s = p;
      @(posedge clk);
      #1;
      cyc++;
      if (out_hs) begin
        if (q.size() == 0) begin
          n_vec++; n_err++; $display("FAIL rand_spurious got p=%h want no output", p_s);
        end else begin
          exp = q.pop_front();
          n_vec++; if (p_s !== exp) begin n_err++; $display("FAIL rand_p%0d got %h want %h", recv, p_s, exp); end
        end
        recv++;
      end
      if (in_hs) begin
        q.push_back(16'(a) * 16'(b));
        sent++;
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    n_vec++; if (recv != 1000 || q.size() != 0) begin
      n_err++; $display("FAIL rand_count got recv=%0d pending=%0d want 1000 0", recv, q.size());
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_corners();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
